// File: rtl/bool3_pipe_unit_if.sv
// Port bundle for bool3_pipe_unit: run/config handshake, operand stream and
// result stream. The controller side uses master, the unit uses slave.
interface bool3_pipe_unit_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 16
);
    logic              run;
    logic [1:0]        mode;
    logic [LEN_W-1:0]  length;
    logic              in_valid;
    logic [DATA_W-1:0] in0;
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [DATA_W-1:0] out0;
    logic              out_valid;
    logic              running;
    logic              done;

    modport master (
        output run, mode, length, in_valid, in0, in1, in2,
        input  out0, out_valid, running, done
    );

    modport slave (
        input  run, mode, length, in_valid, in0, in1, in2,
        output out0, out_valid, running, done
    );
endinterface

// File: rtl/bool3_pipe_unit.sv
// Versat functional unit: selectable 3-input bitwise function (Maj, Ch,
// Parity, bypass) behind a LATENCY-deep pipeline with run-length control.
module bool3_pipe_unit #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned LEN_W   = 16
) (
    input logic              clk,
    input logic              rst,
    bool3_pipe_unit_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic              accept;
    logic              done_c;
    logic [DATA_W-1:0] func_c;
    logic [LATENCY-1:0] vld_q;
    logic [DATA_W-1:0] data_q [LATENCY];

    // Control registers: state, latched configuration and accepted-word count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            count_q <= count_d;
        end
    end

    // Next-state logic: start on run, accept up to len_q words, then drain.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        count_d = count_q;
        accept  = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.run) begin
                    mode_d  = bus.mode;
                    len_d   = bus.length;
                    count_d = '0;
                    state_d = (bus.length == '0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.in_valid && (count_q < len_q)) begin
                    accept  = 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_q == len_q - 1'b1) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Waiting for an empty pipe keeps done one cycle behind the
                // final out_valid, since that result still occupies the last stage.
                if (vld_q == '0) begin
                    done_c  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bitwise function selected by the mode latched at run time.
    always_comb begin
        func_c = bus.in0;
        case (mode_q)
            2'd0:    func_c = (bus.in0 & bus.in1) ^ (bus.in0 & bus.in2) ^ (bus.in1 & bus.in2);
            2'd1:    func_c = (bus.in0 & bus.in1) ^ (~bus.in0 & bus.in2);
            2'd2:    func_c = bus.in0 ^ bus.in1 ^ bus.in2;
            default: func_c = bus.in0;
        endcase
    end

    // Valid bits shift forward every cycle with no stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= LATENCY'({vld_q, accept});
        end
    end

    // Stage 0 data captures the function result on an accepted input.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q[0] <= '0;
        end else if (accept) begin
            data_q[0] <= func_c;
        end
    end

    for (genvar g = 1; g < LATENCY; g++) begin : g_stage
        // Later stages load only behind a valid word, otherwise hold.
        always_ff @(posedge clk) begin
            if (rst) begin
                data_q[g] <= '0;
            end else if (vld_q[g-1]) begin
                data_q[g] <= data_q[g-1];
            end
        end
    end

    assign bus.out0      = data_q[LATENCY-1];
    assign bus.out_valid = vld_q[LATENCY-1];
    assign bus.running   = (state_q != ST_IDLE);
    assign bus.done      = done_c;

endmodule

// File: tb/tb_bool3_pipe_unit.sv
// Directed bench for bool3_pipe_unit: a LATENCY=2 instance for the main
// function/handshake scenarios and a LATENCY=4 instance for mid-run reset.
module tb_bool3_pipe_unit;

    localparam logic [31:0] OPX = 32'hFF00FF00;
    localparam logic [31:0] OPY = 32'hF0F0F0F0;
    localparam logic [31:0] OPZ = 32'hCCCCCCCC;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst4 = 1'b1;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    always #5 clk = ~clk;

    bool3_pipe_unit_if #(.DATA_W(32), .LEN_W(16)) bus ();
    bool3_pipe_unit_if #(.DATA_W(32), .LEN_W(16)) bus4 ();

    bool3_pipe_unit #(.DATA_W(32), .LATENCY(2), .LEN_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    bool3_pipe_unit #(.DATA_W(32), .LATENCY(4), .LEN_W(16)) u_dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (bus4)
    );

    // Burst scenario tables, indexed by clock edge after the run pulse.
    int          pat  [10] = '{1, 0, 1, 1, 0, 1, 1, 0, 0, 0};
    int          e_ov [10] = '{0, 1, 0, 1, 1, 0, 1, 0, 0, 0};
    int          e_dn [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int          e_rn [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic [31:0] e_o  [10] = '{32'hFF00FF00, 32'd1, 32'd1, 32'd2, 32'd3,
                               32'd3, 32'd4, 32'd4, 32'd4, 32'd4};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [1:0] m, input logic [15:0] len);
        bus.run    = 1'b1;
        bus.mode   = m;
        bus.length = len;
        tick();
        bus.run    = 1'b0;
        // Scramble the config ports to show they are not re-sampled mid-run.
        bus.mode   = ~m;
        bus.length = 16'hFFFF;
    endtask

    task automatic run_one(input logic [1:0] m, input logic [31:0] exp, input string tag);
        start(m, 16'd1);
        bus.in0      = OPX;
        bus.in1      = OPY;
        bus.in2      = OPZ;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk({tag, "_ov_early"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_run"},      32'(bus.running),   32'd1);
        tick();
        chk({tag, "_ov"},       32'(bus.out_valid), 32'd1);
        chk({tag, "_out"},      bus.out0,           exp);
        chk({tag, "_nodone"},   32'(bus.done),      32'd0);
        tick();
        chk({tag, "_ov_off"},   32'(bus.out_valid), 32'd0);
        chk({tag, "_done"},     32'(bus.done),      32'd1);
        chk({tag, "_run_dn"},   32'(bus.running),   32'd1);
        tick();
        chk({tag, "_done_off"}, 32'(bus.done),      32'd0);
        chk({tag, "_idle"},     32'(bus.running),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned n_ov;
        int unsigned n_dn;
        logic [31:0] xv;

        bus.run = 1'b0;  bus.mode = '0;  bus.length = '0;  bus.in_valid = 1'b0;
        bus.in0 = '0;    bus.in1 = '0;   bus.in2 = '0;
        bus4.run = 1'b0; bus4.mode = '0; bus4.length = '0; bus4.in_valid = 1'b0;
        bus4.in0 = '0;   bus4.in1 = '0;  bus4.in2 = '0;
        tick();
        tick();
        rst  = 1'b0;
        rst4 = 1'b0;

        // Reset state
        chk("rst_out0", bus.out0,               32'd0);
        chk("rst_ov",   32'(bus.out_valid),     32'd0);
        chk("rst_run",  32'(bus.running),       32'd0);
        chk("rst_done", 32'(bus.done),          32'd0);

        // Functions, operands fixed, one word each
        run_one(2'd0, 32'hFCC0FCC0, "maj");
        run_one(2'd1, 32'hF0CCF0CC, "ch");
        run_one(2'd2, 32'hC33CC33C, "par");
        run_one(2'd3, 32'hFF00FF00, "byp");

        // Burst with bubbles in bypass, plus a stray word during drain
        start(2'd3, 16'd4);
        bus.in1 = 32'h0BADF00D;
        bus.in2 = 32'h12345678;
        xv   = 32'd1;
        n_ov = 0;
        n_dn = 0;
        for (int j = 0; j < 10; j++) begin
            bus.in_valid = (pat[j] != 0);
            bus.in0      = xv;
            if (pat[j] != 0) xv = xv + 32'd1;
            tick();
            chk($sformatf("bst_ov%0d", j),   32'(bus.out_valid), 32'(e_ov[j]));
            chk($sformatf("bst_done%0d", j), 32'(bus.done),      32'(e_dn[j]));
            chk($sformatf("bst_run%0d", j),  32'(bus.running),   32'(e_rn[j]));
            chk($sformatf("bst_out%0d", j),  bus.out0,           e_o[j]);
            if (bus.out_valid) n_ov++;
            if (bus.done) n_dn++;
        end
        bus.in_valid = 1'b0;
        chk("bst_ov_count",   n_ov, 32'd4);
        chk("bst_done_count", n_dn, 32'd1);

        // Zero-length run
        bus.run    = 1'b1;
        bus.mode   = 2'd0;
        bus.length = 16'd0;
        tick();
        bus.run = 1'b0;
        chk("len0_run",   32'(bus.running),   32'd1);
        chk("len0_done",  32'(bus.done),      32'd1);
        chk("len0_ov",    32'(bus.out_valid), 32'd0);
        tick();
        chk("len0_idle",  32'(bus.running),   32'd0);
        chk("len0_dn_off",32'(bus.done),      32'd0);
        chk("len0_ov2",   32'(bus.out_valid), 32'd0);
        chk("len0_hold",  bus.out0,           32'd4);

        // run pulses during RUN and coincident with done are ignored
        start(2'd1, 16'd2);
        bus.in0 = OPX; bus.in1 = OPY; bus.in2 = OPZ;
        bus.in_valid = 1'b1;
        bus.run    = 1'b1;
        bus.mode   = 2'd2;
        bus.length = 16'd5;
        tick();
        bus.run = 1'b0;
        bus.in0 = 32'hFFFFFFFF; bus.in1 = 32'h12345678; bus.in2 = 32'h00000000;
        tick();
        bus.in_valid = 1'b0;
        chk("ign_ov1",   32'(bus.out_valid), 32'd1);
        chk("ign_out1",  bus.out0,           32'hF0CCF0CC);
        tick();
        chk("ign_ov2",   32'(bus.out_valid), 32'd1);
        chk("ign_out2",  bus.out0,           32'h12345678);
        chk("ign_nodn",  32'(bus.done),      32'd0);
        tick();
        chk("ign_done",  32'(bus.done),      32'd1);
        bus.run    = 1'b1;
        bus.mode   = 2'd0;
        bus.length = 16'd1;
        tick();
        bus.run = 1'b0;
        chk("ign_idle",  32'(bus.running),   32'd0);
        chk("ign_dn_off",32'(bus.done),      32'd0);
        tick();
        chk("ign_idle2", 32'(bus.running),   32'd0);
        chk("ign_dn2",   32'(bus.done),      32'd0);

        // Mid-run reset on the LATENCY=4 instance
        bus4.run    = 1'b1;
        bus4.mode   = 2'd3;
        bus4.length = 16'd8;
        tick();
        bus4.run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus4.in0      = 32'(i + 1);
            bus4.in_valid = 1'b1;
            tick();
            chk($sformatf("l4_ov%0d", i), 32'(bus4.out_valid), (i == 3) ? 32'd1 : 32'd0);
        end
        chk("l4_out_first", bus4.out0, 32'd1);
        bus4.in_valid = 1'b0;
        tick();
        chk("l4_out_second", bus4.out0, 32'd2);
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        chk("l4rst_out0", bus4.out0,               32'd0);
        chk("l4rst_ov",   32'(bus4.out_valid),     32'd0);
        chk("l4rst_run",  32'(bus4.running),       32'd0);
        chk("l4rst_done", 32'(bus4.done),          32'd0);
        n_dn = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus4.done || bus4.out_valid) n_dn++;
        end
        chk("l4rst_quiet", n_dn, 32'd0);

        // Fresh Maj run after the abort
        bus4.run    = 1'b1;
        bus4.mode   = 2'd0;
        bus4.length = 16'd1;
        tick();
        bus4.run = 1'b0;
        bus4.in0 = OPX; bus4.in1 = OPY; bus4.in2 = OPZ;
        bus4.in_valid = 1'b1;
        tick();
        bus4.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("l4new_ov_early%0d", k), 32'(bus4.out_valid), 32'd0);
            tick();
        end
        chk("l4new_ov",   32'(bus4.out_valid), 32'd1);
        chk("l4new_out",  bus4.out0,           32'hFCC0FCC0);
        chk("l4new_nodn", 32'(bus4.done),      32'd0);
        tick();
        chk("l4new_done", 32'(bus4.done),      32'd1);
        chk("l4new_ov0",  32'(bus4.out_valid), 32'd0);
        tick();
        chk("l4new_idle", 32'(bus4.running),   32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
